perf_sig_monitor: RTL
=====================

# perf_sig_monitor

Synthesizable test-status and performance monitor that snoops the rv32i data-memory write port (same signals that drive d_mem) and the core's retire strobe. It keeps shadow copies of the PASS-flag word and four signature words, and counts cycles and retired instructions from reset release until PASS or timeout. It then freezes and exposes results through a registered read port, replacing bench-side memory peeking on FPGA/silicon runs.

## Interface
Parameters:
- PASS_ADDR, 8'h08: byte address of PASS-flag word (word-aligned).
- SIG_BASE, 8'h80: byte address of signature word 0; words 1..3 at +4/+8/+C.
- EXP0..EXP3, 32'h44332211 / 32'h88776655 / 32'hCCAA8866 / 32'h00000001: expected signature values.
- TIMEOUT_CYCLES, 50000: cycle budget before TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- n_rst  in  1  reset; one clock; reset is synchronous and active-low.
- wr_en  in  1  data-memory write strobe from core.
- wr_addr  in  8  byte address of store.
- mode  in  2  store size: 00 byte, 01 half, 10/11 word.
- d_in  in  32  store data, low-aligned (byte in [7:0], half in [15:0]).
- retire  in  1  one pulse per retired instruction (valid_W).
- rd_sel  in  3  result select.
- rd_data  out  32  registered result word.
- done  out  1  PASS or TIMEOUT reached (sticky until reset).
- pass  out  1  PASS flag observed.
- timeout  out  1  budget exhausted without PASS.
- sig_ok  out  1  all four signature shadows equal EXP0..EXP3; valid when done.

## Operation
- States: RUN (after reset), DONE_PASS, DONE_TO. No idle state; counting starts on the first edge with n_rst high.
- Shadow registers: pass_sh, sig_sh[0..3], 32 bits each, reset 0. A write updates a shadow if wr_addr[7:2] matches its word address. Lane merge:
  - byte: lane wr_addr[1:0] ← d_in[7:0].
  - half: lanes {wr_addr[1],0}+{1,0} ← d_in[15:0]; wr_addr[0] ignored.
  - word: all lanes ← d_in; wr_addr[1:0] ignored.
  - Other lanes keep their values.
- RUN, each edge:
  - cycles += 1.
  - retired += 1 if retire.
  - Apply shadow writes.
  - If the merged next pass_sh == 1 → DONE_PASS.
  - Else if the incremented cycles == TIMEOUT_CYCLES → DONE_TO.
  - PASS wins if both hold on the same edge.
- DONE_*: counters, shadows and state frozen. Writes and retire pulses are ignored.
- Counters are 32-bit and wrap modulo 2^32. No saturation; the timeout fires first for any sane parameter.
- sig_ok = (sig_sh == EXP) for all four words, computed combinationally from the frozen shadows.
- rd_sel map:
  - 0: {28'b0, sig_ok, timeout, pass, done}
  - 1: cycles
  - 2: retired
  - 3..6: sig_sh[0..3]
  - 7: pass_sh
- Reset (n_rst low at an edge) at any time, including mid-RUN or DONE: all registers and outputs return to reset values. Re-entry to RUN is clean.

## Timing
- Reset values: rd_data=0, done=0, pass=0, timeout=0, cycles=0, retired=0, all shadows 0. sig_ok reflects shadows vs EXP, so it is 0 unless EXPn are all 0.
- A store presented at edge k is visible in its shadow after edge k.
- done/pass rise after that same edge k, with zero added latency.
- cycles equals the number of RUN edges, including the terminating edge. A PASS store on the first edge after reset release gives cycles=1.
- A retire pulse on the terminating edge is counted.
- rd_data is registered: rd_sel sampled at edge k appears after edge k (1-cycle latency). It is updated every cycle, including during reset (driven 0).
- TIMEOUT: DONE_TO is entered on the edge where cycles becomes TIMEOUT_CYCLES. cycles reads exactly TIMEOUT_CYCLES.
- Writes to non-monitored addresses have no effect on the monitor.

## Test plan
- Word PASS: release reset, 10 idle cycles, then sw 0x00000001 to 0x08 → pass=done=1 after that edge, cycles=11, timeout=0.
- Byte-merged PASS: sb 0x01 to 0x08, then sb 0x00 to 0x09/0x0A/0x0B. Expect pass_sh==1 only if the upper lanes are already 0. Repeat after a prior sw 0xFFFFFFFF: no PASS until all three upper bytes are cleared, then PASS on the last store.
- Signatures: sw EXP0..EXP3 to 0x80..0x8C, then PASS → sig_ok=1. Alternatively, sh 0x8866 to 0x88 plus sh 0xCCAA to 0x8A → rd_sel=5 returns 0xCCAA8866. One corrupted word → sig_ok=0.
- Retire/CPI: 7 retire pulses in 20 cycles, then PASS on cycle 20 with retire high → rd_sel=2 returns 8, rd_sel=1 returns 20. A later store or retire does not change either.
- Timeout: TIMEOUT_CYCLES=100 with no PASS → timeout=done=1 after edge 100, cycles=100, pass=0. PASS store on edge 100 → pass=1, timeout=0.
- Reset mid-operation: n_rst low for 1 edge at cycle 50 of a run with 20 retires → all outputs 0 next cycle. The rerun counts from 1 again.

Source files
------------

// File: rtl/perf_sig_monitor.sv
// Test-status and performance monitor: snoops data-memory stores and retire pulses,
// shadows the PASS flag and signature words, and counts cycles/retires until PASS or timeout.
module perf_sig_monitor #(
  parameter logic [7:0]  PASS_ADDR      = 8'h08,
  parameter logic [7:0]  SIG_BASE       = 8'h80,
  parameter logic [31:0] EXP0           = 32'h44332211,
  parameter logic [31:0] EXP1           = 32'h88776655,
  parameter logic [31:0] EXP2           = 32'hCCAA8866,
  parameter logic [31:0] EXP3           = 32'h00000001,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [1:0]  mode,
  input  logic [31:0] d_in,
  input  logic        retire,
  input  logic [2:0]  rd_sel,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        sig_ok,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {RUN = 2'd0, DONE_PASS = 2'd1, DONE_TO = 2'd2} state_e;

  localparam logic [31:0] EXP [4] = '{EXP0, EXP1, EXP2, EXP3};

  state_e      state_q;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] pass_q, pass_d;
  logic [31:0] sig_q [4];
  logic [31:0] sig_d [4];
  logic [31:0] rd_data_q, rd_mux;

  // Byte-lane merge of a store into a shadow word; d_in is low-aligned.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] lane,
                                        input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    case (sz)
      2'b00:   r[{lane, 3'b000} +: 8]       = d[7:0];
      2'b01:   r[{lane[1], 4'b0000} +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    pass_d = pass_q;
    if (wr_en && (wr_addr[7:2] == PASS_ADDR[7:2]))
      pass_d = merge(pass_q, wr_addr[1:0], mode, d_in);
    for (int i = 0; i < 4; i++) begin
      sig_d[i] = sig_q[i];
      if (wr_en && (wr_addr[7:2] == SIG_BASE[7:2] + 6'(i)))
        sig_d[i] = merge(sig_q[i], wr_addr[1:0], mode, d_in);
    end
    cycles_d  = cycles_q + 32'd1;
    retired_d = retired_q + {31'b0, retire};
  end

  always_comb begin
    sig_ok = 1'b1;
    for (int i = 0; i < 4; i++)
      if (sig_q[i] != EXP[i]) sig_ok = 1'b0;
  end

  assign done      = (state_q != RUN);
  assign pass      = (state_q == DONE_PASS);
  assign timeout   = (state_q == DONE_TO);
  assign dbg_state = state_q;

  always_comb begin
    rd_mux = '0;
    case (rd_sel)
      3'd0: rd_mux = {28'b0, sig_ok, timeout, pass, done};
      3'd1: rd_mux = cycles_q;
      3'd2: rd_mux = retired_q;
      3'd3: rd_mux = sig_q[0];
      3'd4: rd_mux = sig_q[1];
      3'd5: rd_mux = sig_q[2];
      3'd6: rd_mux = sig_q[3];
      default: rd_mux = pass_q;
    endcase
  end

  // Everything freezes once a DONE state is reached; only reset leaves it.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q   <= RUN;
      cycles_q  <= '0;
      retired_q <= '0;
      pass_q    <= '0;
      for (int i = 0; i < 4; i++) sig_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_mux;
      if (state_q == RUN) begin
        cycles_q  <= cycles_d;
        retired_q <= retired_d;
        pass_q    <= pass_d;
        for (int i = 0; i < 4; i++) sig_q[i] <= sig_d[i];
        if (pass_d == 32'd1)
          state_q <= DONE_PASS;
        else if (cycles_d == 32'(TIMEOUT_CYCLES))
          state_q <= DONE_TO;
      end
    end
  end

  assign rd_data = rd_data_q;

endmodule
